// File: rtl/clk_pkg.sv
// Shared types and sizing helpers for the PLL lock monitor.
package clk_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        QUALIFY   = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        PLL_RESET = 3'd4
    } state_e;

    // Width of a counter that counts 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2
    import clk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock, sequences downstream reset and retries the PLL
// when lock never qualifies within the timeout window.
module pll_lock_monitor
    import clk_pkg::*;
#(
    parameter int LOCK_CYCLES    = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PLL_RST_CYCLES = 32,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [3:0] retry_count,
    output logic       fault
);

    localparam int LW = cnt_w(LOCK_CYCLES);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int PW = cnt_w(PLL_RST_CYCLES);

    localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PLL_RST_CYCLES - 1);
    localparam logic [3:0]    R_LIM  = 4'(MAX_RETRY);

    logic          lock_s;
    state_e        state_q, state_d;
    logic [LW-1:0] qcnt_q, qcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    loss_q, loss_d;
    logic [3:0]    retry_q, retry_d;
    logic          fault_q, fault_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        hcnt_d  = hcnt_q;
        tcnt_d  = tcnt_q;
        pcnt_d  = pcnt_q;
        loss_d  = loss_q;
        retry_d = retry_q;
        unique case (state_q)
            WAIT_LOCK, QUALIFY: begin
                // Timeout wins over any lock progress on the same edge.
                if (tcnt_q == T_LAST) begin
                    state_d = PLL_RESET;
                    tcnt_d  = '0;
                    pcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (state_q == WAIT_LOCK) begin
                        if (lock_s) begin
                            state_d = QUALIFY;
                            qcnt_d  = '0;
                        end
                    end else if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (qcnt_q == L_LAST) begin
                        state_d = HOLD;
                        hcnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        qcnt_d = qcnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (hcnt_q == H_LAST) begin
                    state_d = RUN;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            PLL_RESET: begin
                if (pcnt_q == P_LAST) begin
                    state_d = WAIT_LOCK;
                    if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        fault_d = fault_q | (retry_d >= R_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            qcnt_q  <= '0;
            hcnt_q  <= '0;
            tcnt_q  <= '0;
            pcnt_q  <= '0;
            loss_q  <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            hcnt_q  <= hcnt_d;
            tcnt_q  <= tcnt_d;
            pcnt_q  <= pcnt_d;
            loss_q  <= loss_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
        end
    end

    assign pll_rst     = (state_q == PLL_RESET);
    assign ready       = (state_q == RUN);
    assign sys_rst     = (state_q != RUN);
    assign loss_count  = loss_q;
    assign retry_count = retry_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: directed scenarios plus random
// lock patterns checked against a cycle-level behavioural model.
module tb_pll_lock_monitor;

    localparam int LC = 8;
    localparam int HC = 4;
    localparam int TC = 64;
    localparam int PC = 4;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [7:0] loss_count;
    logic [3:0] retry_count;

    pll_lock_monitor #(
        .LOCK_CYCLES    (LC),
        .HOLD_CYCLES    (HC),
        .TIMEOUT_CYCLES (TC),
        .PLL_RST_CYCLES (PC),
        .MAX_RETRY      (MR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .loss_count  (loss_count),
        .retry_count (retry_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] loss;
        logic [3:0] retry;
        logic       fault;
    } outs_t;

    outs_t exp_q[$];
    int    edge_q[$];
    int    checks = 0;
    int    failures = 0;
    int    edge_n = 0;

    int    rise_e = -1, fall_e = -1, pll_e = -1, pll_hi = 0;
    logic  prev_ready = 1'b0, prev_pll = 1'b0;
    outs_t m_exp, m_act;
    int    m_edge;

    // Behavioural model state: lock history and plain integer counters.
    localparam int M_WAIT = 0, M_QUAL = 1, M_HOLD = 2, M_RUN = 3, M_PRST = 4;
    int mode = M_WAIT;
    bit s1 = 0, s2 = 0;
    int good = 0, held = 0, idle = 0, pulse = 0;
    int m_loss = 0, m_retry = 0;
    bit m_fault = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    task automatic model_edge(input bit r, input bit l, output outs_t o);
        bit ls;
        if (r) begin
            mode = M_WAIT; s1 = 0; s2 = 0;
            good = 0; held = 0; idle = 0; pulse = 0;
            m_loss = 0; m_retry = 0; m_fault = 0;
        end else begin
            ls = s2; s2 = s1; s1 = l;
            case (mode)
                M_WAIT, M_QUAL: begin
                    idle++;
                    if (idle == TC) begin
                        mode = M_PRST; idle = 0; pulse = 0;
                    end else if (mode == M_WAIT) begin
                        if (ls) begin mode = M_QUAL; good = 0; end
                    end else if (!ls) begin
                        mode = M_WAIT;
                    end else begin
                        good++;
                        if (good == LC) begin mode = M_HOLD; held = 0; idle = 0; end
                    end
                end
                M_HOLD: begin
                    if (!ls) mode = M_WAIT;
                    else begin
                        held++;
                        if (held == HC) mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        mode = M_WAIT;
                        if (m_loss < 255) m_loss++;
                    end
                end
                M_PRST: begin
                    pulse++;
                    if (pulse == PC) begin
                        mode = M_WAIT;
                        if (m_retry < 15) m_retry++;
                        if (m_retry >= MR) m_fault = 1;
                    end
                end
                default: mode = M_WAIT;
            endcase
        end
        o.pll_rst = (mode == M_PRST);
        o.sys_rst = (mode != M_RUN);
        o.ready   = (mode == M_RUN);
        o.loss    = 8'(m_loss);
        o.retry   = 4'(m_retry);
        o.fault   = m_fault;
    endtask

    task automatic step(input bit r, input bit l);
        outs_t o;
        rst = r;
        locked = l;
        @(posedge clk);
        edge_n++;
        model_edge(r, l, o);
        exp_q.push_back(o);
        edge_q.push_back(edge_n);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_edge = edge_q.pop_front();
            m_act = {pll_rst, sys_rst, ready, loss_count, retry_count, fault};
            checks++;
            if (m_act !== m_exp) begin
                failures++;
                $display("FAIL outputs edge %0d: got pll_rst=%b sys_rst=%b ready=%b loss=%0d retry=%0d fault=%b expected pll_rst=%b sys_rst=%b ready=%b loss=%0d retry=%0d fault=%b",
                         m_edge, m_act.pll_rst, m_act.sys_rst, m_act.ready, m_act.loss,
                         m_act.retry, m_act.fault, m_exp.pll_rst, m_exp.sys_rst,
                         m_exp.ready, m_exp.loss, m_exp.retry, m_exp.fault);
            end
            if (ready && !prev_ready) rise_e = m_edge;
            if (!ready && prev_ready) fall_e = m_edge;
            if (pll_rst && !prev_pll) pll_e = m_edge;
            if (pll_rst) pll_hi++;
            prev_ready = ready;
            prev_pll = pll_rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f, h0;

        // Clean lock: locked first sampled high at relative edge 10.
        repeat (3) step(1, 0);
        base = edge_n;
        settle();
        check("reset_sys_rst", sys_rst, 1);
        check("reset_ready", ready, 0);
        h0 = pll_hi;
        for (int e = 1; e <= 40; e++) step(0, e >= 10);
        settle();
        check("clean_ready_edge", rise_e - base, 24);
        check("clean_sys_rst", sys_rst, 0);
        check("clean_no_pll_rst", pll_hi - h0, 0);

        // One-cycle glitch at relative edge 6 restarts qualification.
        repeat (2) step(1, 0);
        base = edge_n;
        for (int e = 1; e <= 30; e++) step(0, e != 6);
        settle();
        check("glitch_ready_edge", rise_e - base, 21);

        // Loss in RUN, then relock.
        f = edge_n + 1;
        repeat (3) step(0, 0);
        for (int e = 0; e < 20; e++) step(0, 1);
        settle();
        check("loss_fall_edge", fall_e - f, 2);
        check("loss_count_one", loss_count, 1);
        check("relock_ready_edge", rise_e - (f + 3), 14);

        // No lock: two timeouts and PLL reset pulses.
        repeat (2) step(1, 0);
        base = edge_n;
        settle();
        h0 = pll_hi;
        for (int e = 1; e <= 70; e++) step(0, 0);
        settle();
        check("pll_first_edge", pll_e - base, 64);
        check("retry_one", retry_count, 1);
        check("fault_clear", fault, 0);
        for (int e = 71; e <= 140; e++) step(0, 0);
        settle();
        check("pll_second_edge", pll_e - base, 132);
        check("pll_high_cycles", pll_hi - h0, 8);
        check("retry_two", retry_count, 2);
        check("fault_set", fault, 1);

        // Reset in the middle of the third pulse.
        for (int e = 141; e <= 202; e++) step(0, 0);
        settle();
        check("pll_before_rst", pll_rst, 1);
        step(1, 0);
        settle();
        check("rst_pll_rst", pll_rst, 0);
        check("rst_retry", retry_count, 0);
        check("rst_fault", fault, 0);
        check("rst_loss", loss_count, 0);

        // 300 forced losses saturate the loss counter.
        step(1, 0);
        for (int i = 0; i < 300; i++) begin
            repeat (16) step(0, 1);
            repeat (3) step(0, 0);
        end
        settle();
        check("loss_saturated", loss_count, 255);

        // Random lock patterns with occasional resets.
        step(1, 0);
        for (int i = 0; i < 200; i++) begin
            int len;
            bit v;
            len = $urandom_range(1, (i % 4 == 0) ? 90 : 20);
            v = i[0];
            for (int j = 0; j < len; j++) step($urandom_range(0, 199) == 0, v);
        end
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
